// File: rtl/freq_meter_pkg.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter_pkg
// Purpose  : Shared state encoding and default sizing for the frequency meter.
// Revision : 1.0
// ============================================================================
package freq_meter_pkg;

    typedef enum logic {
        ST_MEASURE = 1'b0,
        ST_LATCH   = 1'b1
    } state_e;

    localparam int unsigned GATE_CYCLES_DEF = 100000000;
    localparam int unsigned CNT_W_DEF       = 27;

endpackage
`default_nettype wire

// File: rtl/sync_edge_det.sv
`default_nettype none
// ============================================================================
// Module   : sync_edge_det
// Purpose  : Two-flop synchroniser followed by a rising-edge detector.
// Revision : 1.0
// ============================================================================
module sync_edge_det (
    input  logic clk,
    input  logic rst,
    input  logic d_async,
    output logic rise
);

    logic sync1_q;
    logic sync2_q;
    logic prev_q;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            prev_q  <= 1'b0;
        end else begin
            sync1_q <= d_async;
            sync2_q <= sync1_q;
            prev_q  <= sync2_q;
        end
    end

    assign rise = sync2_q & ~prev_q;

endmodule
`default_nettype wire

// File: rtl/freq_meter.sv
`default_nettype none
// ============================================================================
// Module   : freq_meter
// Purpose  : Counts rising edges of sig_in over a fixed gate window of clk.
//            Optional FREQ_METER_HOLD_EN adds a 'hold' input that freezes
//            the reported result.
// Revision : 1.0
// ============================================================================
module freq_meter
    import freq_meter_pkg::*;
#(
    parameter int unsigned GATE_CYCLES = GATE_CYCLES_DEF,
    parameter int unsigned CNT_W       = CNT_W_DEF
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sig_in,
`ifdef FREQ_METER_HOLD_EN
    input  logic             hold,
`endif
    output logic [CNT_W-1:0] freq_out,
    output logic             valid,
    output logic             ovf
);

    localparam int unsigned GATE_W = $clog2(GATE_CYCLES);
    localparam logic [GATE_W-1:0] GATE_LAST = GATE_W'(GATE_CYCLES - 1);
    localparam logic [CNT_W-1:0]  CNT_MAX   = {CNT_W{1'b1}};

    state_e            state_q;
    logic [GATE_W-1:0] gate_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_q;
    logic [CNT_W-1:0]  edge_cnt_d;
    logic              sat_q;
    logic              sat_d;
    logic [CNT_W-1:0]  freq_out_q;
    logic              ovf_q;
    logic              valid_q;
    logic              sig_rise;
    logic              upd_en;

    sync_edge_det u_sync (
        .clk     (clk),
        .rst     (rst),
        .d_async (sig_in),
        .rise    (sig_rise)
    );

`ifdef FREQ_METER_HOLD_EN
    assign upd_en = ~hold;
`else
    assign upd_en = 1'b1;
`endif

    // Saturating increment; ovf flags edges that were actually lost past the max.
    always_comb begin
        edge_cnt_d = edge_cnt_q;
        sat_d      = sat_q;
        if (sig_rise) begin
            if (edge_cnt_q == CNT_MAX) begin
                sat_d = 1'b1;
            end else begin
                edge_cnt_d = edge_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q    <= ST_MEASURE;
            gate_cnt_q <= '0;
            edge_cnt_q <= '0;
            sat_q      <= 1'b0;
            freq_out_q <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            case (state_q)
                ST_MEASURE: begin
                    edge_cnt_q <= edge_cnt_d;
                    sat_q      <= sat_d;
                    if (gate_cnt_q == GATE_LAST) begin
                        gate_cnt_q <= '0;
                        state_q    <= ST_LATCH;
                    end else begin
                        gate_cnt_q <= gate_cnt_q + GATE_W'(1);
                    end
                end
                ST_LATCH: begin
                    if (upd_en) begin
                        freq_out_q <= edge_cnt_q;
                        ovf_q      <= sat_q;
                        valid_q    <= 1'b1;
                    end
                    // An edge seen during the latch cycle opens the next window.
                    edge_cnt_q <= CNT_W'(sig_rise);
                    sat_q      <= 1'b0;
                    gate_cnt_q <= '0;
                    state_q    <= ST_MEASURE;
                end
                default: begin
                    state_q <= ST_MEASURE;
                end
            endcase
        end
    end

    assign freq_out = freq_out_q;
    assign valid    = valid_q;
    assign ovf      = ovf_q;

endmodule
`default_nettype wire
